// File: rtl/vex_job_scheduler_pkg.sv
// Shared types for the compute_vex job scheduler: FSM state encoding, the
// job descriptor layout and default run length.
package vex_job_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_RUN    = 3'd2,
    S_ABORT  = 3'd3,
    S_COMMIT = 3'd4
  } state_e;

  localparam int JOB_W          = 196;
  localparam int NUM_WRITES_DEF = 8000;
  localparam int WCNT_W         = 14;

  typedef struct packed {
    logic [63:0] k_over_s;
    logic [63:0] log_lambda_up;
    logic [63:0] log_lambda_down;
    logic [3:0]  tag;
  } job_t;

endpackage

// File: rtl/vex_job_scheduler_job_queue.sv
// Small synchronous FIFO holding pending job descriptors; a pushed entry is
// visible at the head from the following cycle (no bypass).
module vex_job_scheduler_job_queue #(
  parameter int DEPTH = 2,
  parameter int W     = 196
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, rptr_q;
  logic         do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/vex_job_scheduler.sv
// Issues queued pricing jobs to compute_vex one at a time, watchdogs each run
// and publishes results through two ping-pong exercise-value banks.
module vex_job_scheduler
  import vex_job_scheduler_pkg::*;
#(
  parameter int NUM_WRITES  = NUM_WRITES_DEF,
  parameter int TIMEOUT_CYC = 16384,
  parameter int QDEPTH      = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [63:0] job_k_over_s,
  input  logic [63:0] job_log_lambda_up,
  input  logic [63:0] job_log_lambda_down,
  input  logic [3:0]  job_tag,
  output logic        vex_start,
  output logic        vex_nrst,
  output logic [63:0] vex_k_over_s,
  output logic [63:0] vex_log_lambda_up,
  output logic [63:0] vex_log_lambda_down,
  input  logic [7:0]  vex_wren,
  input  logic        vex_done,
  output logic        bank_sel,
  output logic        res_valid,
  output logic        res_bank,
  output logic [3:0]  res_tag,
  output logic        res_error,
  input  logic        res_ready,
  output logic        busy
);

  localparam int                TW        = $clog2(TIMEOUT_CYC);
  localparam logic [WCNT_W-1:0] WR_TARGET = WCNT_W'(NUM_WRITES);
  localparam logic [TW-1:0]     TO_LAST   = TW'(TIMEOUT_CYC - 1);

  function automatic logic [WCNT_W-1:0] sat_inc_w(input logic [WCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [TW-1:0] sat_inc_t(input logic [TW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d, wcnt_inc;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              err_q, err_d;
  logic              abrt_q, abrt_d;
  logic              vex_nrst_q;

  logic              q_push, q_pop, q_full, q_empty;
  job_t              q_din, q_dout;

  logic [63:0]       kos_q, up_q, dn_q;
  logic [3:0]        tag_q;

  logic              wr_bank_q, rd_bank_q;
  logic [1:0]        bank_full_q, bank_full_d;
  logic [1:0][3:0]   bank_tag_q;
  logic [1:0]        bank_err_q;
  logic              commit, res_take;

  assign q_din  = '{k_over_s: job_k_over_s, log_lambda_up: job_log_lambda_up,
                    log_lambda_down: job_log_lambda_down, tag: job_tag};
  assign q_push = job_valid & ~q_full;

  vex_job_scheduler_job_queue #(.DEPTH(QDEPTH), .W(JOB_W)) u_queue (
    .clk     (clk),
    .nrst    (nrst),
    .push_i  (q_push),
    .pop_i   (q_pop),
    .din_i   (q_din),
    .dout_o  (q_dout),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  always_comb begin
    state_d  = state_q;
    q_pop    = 1'b0;
    wcnt_inc = wcnt_q;
    wcnt_d   = wcnt_q;
    tcnt_d   = tcnt_q;
    err_d    = err_q;
    abrt_d   = abrt_q;
    case (state_q)
      S_IDLE: begin
        if (!q_empty && !bank_full_q[wr_bank_q]) begin
          state_d = S_ISSUE;
          q_pop   = 1'b1;
          wcnt_d  = '0;
          tcnt_d  = '0;
          err_d   = 1'b0;
        end
      end
      S_ISSUE: state_d = S_RUN;
      S_RUN: begin
        // A strobe coincident with done is included in the final count.
        wcnt_inc = (|vex_wren) ? sat_inc_w(wcnt_q) : wcnt_q;
        wcnt_d   = wcnt_inc;
        tcnt_d   = sat_inc_t(tcnt_q);
        if (vex_done) begin
          err_d   = (wcnt_inc != WR_TARGET);
          state_d = S_COMMIT;
        end else if (tcnt_q == TO_LAST) begin
          err_d   = 1'b1;
          abrt_d  = 1'b0;
          state_d = S_ABORT;
        end
      end
      S_ABORT: begin
        if (abrt_q) state_d = S_COMMIT;
        else        abrt_d  = 1'b1;
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      tcnt_q     <= '0;
      err_q      <= 1'b0;
      abrt_q     <= 1'b0;
      vex_nrst_q <= 1'b0;
      kos_q      <= '0;
      up_q       <= '0;
      dn_q       <= '0;
      tag_q      <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      tcnt_q     <= tcnt_d;
      err_q      <= err_d;
      abrt_q     <= abrt_d;
      vex_nrst_q <= (state_d != S_ABORT);
      if (q_pop) begin
        kos_q <= q_dout.k_over_s;
        up_q  <= q_dout.log_lambda_up;
        dn_q  <= q_dout.log_lambda_down;
        tag_q <= q_dout.tag;
      end
    end
  end

  assign commit   = (state_q == S_COMMIT);
  assign res_take = bank_full_q[rd_bank_q] & res_ready;

  // Set and clear never hit the same bank, so applying both is safe.
  always_comb begin
    bank_full_d = bank_full_q;
    if (commit)   bank_full_d[wr_bank_q] = 1'b1;
    if (res_take) bank_full_d[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      bank_full_q <= '0;
      bank_tag_q  <= '0;
      bank_err_q  <= '0;
    end else begin
      bank_full_q <= bank_full_d;
      if (commit) begin
        bank_tag_q[wr_bank_q] <= tag_q;
        bank_err_q[wr_bank_q] <= err_q;
        wr_bank_q             <= ~wr_bank_q;
      end
      if (res_take) rd_bank_q <= ~rd_bank_q;
    end
  end

  assign job_ready           = ~q_full;
  assign vex_start           = (state_q == S_ISSUE);
  assign vex_nrst            = vex_nrst_q;
  assign vex_k_over_s        = kos_q;
  assign vex_log_lambda_up   = up_q;
  assign vex_log_lambda_down = dn_q;
  assign bank_sel            = wr_bank_q;
  assign res_valid           = bank_full_q[rd_bank_q];
  assign res_bank            = rd_bank_q;
  assign res_tag             = bank_tag_q[rd_bank_q];
  assign res_error           = bank_err_q[rd_bank_q];
  assign busy                = (state_q != S_IDLE) | ~q_empty;

endmodule

// File: tb/tb_vex_job_scheduler.sv
// Directed bench for vex_job_scheduler with a behavioural compute_vex model and
// a result scoreboard; run lengths are scaled down through the parameters.
module tb_vex_job_scheduler;

  localparam int NW  = 40;
  localparam int TO  = 256;
  localparam int LIM = 2000;

  logic        clk, nrst;
  logic        job_valid, job_ready;
  logic [63:0] job_k_over_s, job_log_lambda_up, job_log_lambda_down;
  logic [3:0]  job_tag;
  logic        vex_start, vex_nrst;
  logic [63:0] vex_k_over_s, vex_log_lambda_up, vex_log_lambda_down;
  logic [7:0]  vex_wren;
  logic        vex_done, bank_sel;
  logic        res_valid, res_bank, res_error, res_ready, busy;
  logic [3:0]  res_tag;

  typedef struct packed {
    logic [63:0] k;
    logic [3:0]  tag;
    logic        err;
    logic        bank;
  } exp_t;

  exp_t        exp_q[$];
  int          mode_q[$];
  logic [63:0] obs_k_q[$];
  logic        obs_bank_q[$];
  int          start_cnt = 0;
  int          vectors = 0;
  int          fails = 0;
  logic        exp_bank = 1'b0;

  vex_job_scheduler #(.NUM_WRITES(NW), .TIMEOUT_CYC(TO), .QDEPTH(2)) dut (
    .clk                 (clk),
    .nrst                (nrst),
    .job_valid           (job_valid),
    .job_ready           (job_ready),
    .job_k_over_s        (job_k_over_s),
    .job_log_lambda_up   (job_log_lambda_up),
    .job_log_lambda_down (job_log_lambda_down),
    .job_tag             (job_tag),
    .vex_start           (vex_start),
    .vex_nrst            (vex_nrst),
    .vex_k_over_s        (vex_k_over_s),
    .vex_log_lambda_up   (vex_log_lambda_up),
    .vex_log_lambda_down (vex_log_lambda_down),
    .vex_wren            (vex_wren),
    .vex_done            (vex_done),
    .bank_sel            (bank_sel),
    .res_valid           (res_valid),
    .res_bank            (res_bank),
    .res_tag             (res_tag),
    .res_error           (res_error),
    .res_ready           (res_ready),
    .busy                (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // compute_vex model: mode 0 = NW strobes then done, 1 = NW-1 strobes, 2 = hang.
  initial begin
    int  md;
    int  n;
    logic aborted;
    vex_wren = '0;
    vex_done = 1'b0;
    forever begin
      @(negedge clk);
      if (nrst && vex_start) begin
        md = (mode_q.size() > 0) ? mode_q.pop_front() : 0;
        obs_k_q.push_back(vex_k_over_s);
        obs_bank_q.push_back(bank_sel);
        start_cnt++;
        if (md != 2) begin
          n = (md == 1) ? NW - 1 : NW;
          aborted = 1'b0;
          for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!nrst) begin
              aborted = 1'b1;
              break;
            end
            vex_wren = 8'(1 << (i % 8));
          end
          @(negedge clk);
          vex_wren = '0;
          if (!aborted && nrst) begin
            vex_done = 1'b1;
            @(negedge clk);
            vex_done = 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic push_job(input logic [3:0] tag, input int mode);
    int w;
    @(negedge clk);
    job_valid           = 1'b1;
    job_tag             = tag;
    job_k_over_s        = 64'h3FF0_0000_0000_0000 | 64'(tag);
    job_log_lambda_up   = 64'h3FB9_9999_9999_999A ^ 64'(tag);
    job_log_lambda_down = 64'hBFB9_9999_9999_999A ^ 64'(tag);
    w = 0;
    while (!job_ready && w < LIM) begin
      @(negedge clk);
      w++;
    end
    chk("push_ready", 64'(job_ready), 64'd1);
    mode_q.push_back(mode);
    exp_q.push_back('{k: job_k_over_s, tag: tag, err: (mode != 0), bank: exp_bank});
    exp_bank = ~exp_bank;
    @(posedge clk);
    #1 job_valid = 1'b0;
  endtask

  task automatic wait_result(input string nm);
    int   w;
    exp_t e;
    w = 0;
    while (!res_valid && w < LIM) begin
      @(negedge clk);
      w++;
    end
    chk({nm, ".res_valid"}, 64'(res_valid), 64'd1);
    vectors++;
    assert (exp_q.size() > 0 && obs_k_q.size() > 0) else begin
      fails++;
      $error("FAIL %s.scoreboard: observed result with %0d expected, %0d issued", nm,
             exp_q.size(), obs_k_q.size());
      return;
    end
    e = exp_q.pop_front();
    chk({nm, ".res_bank"},  64'(res_bank),  64'(e.bank));
    chk({nm, ".res_tag"},   64'(res_tag),   64'(e.tag));
    chk({nm, ".res_error"}, 64'(res_error), 64'(e.err));
    chk({nm, ".issue_k"},   obs_k_q.pop_front(), e.k);
    chk({nm, ".issue_bank"}, 64'(obs_bank_q.pop_front()), 64'(e.bank));
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    exp_q.delete();
    mode_q.delete();
    obs_k_q.delete();
    obs_bank_q.delete();
    exp_bank = 1'b0;
  endtask

  initial begin
    int s0;
    int w;
    int lowc;
    nrst = 1'b1;
    job_valid = 1'b0;
    job_tag = '0;
    job_k_over_s = '0;
    job_log_lambda_up = '0;
    job_log_lambda_down = '0;
    res_ready = 1'b0;
    #2 nrst = 1'b0;
    #1;
    chk("rst.job_ready", 64'(job_ready), 64'd1);
    chk("rst.vex_nrst",  64'(vex_nrst),  64'd0);
    chk("rst.vex_start", 64'(vex_start), 64'd0);
    chk("rst.res_valid", 64'(res_valid), 64'd0);
    chk("rst.busy",      64'(busy),      64'd0);
    chk("rst.bank_sel",  64'(bank_sel),  64'd0);
    chk("rst.vex_k",     vex_k_over_s,   64'd0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1 chk("rst.vex_nrst_rel", 64'(vex_nrst), 64'd1);

    // 1) single job
    s0 = start_cnt;
    push_job(4'd3, 0);
    wait_result("t1");
    chk("t1.starts", 64'(start_cnt - s0), 64'd1);
    release_result();

    // 2) four jobs with the reader stalled
    apply_reset();
    s0 = start_cnt;
    push_job(4'd4, 0);
    push_job(4'd5, 0);
    push_job(4'd6, 0);
    push_job(4'd7, 0);
    repeat (NW + 20) @(negedge clk);
    chk("t2.job_ready_low", 64'(job_ready), 64'd0);
    chk("t2.busy",          64'(busy),      64'd1);
    chk("t2.starts_stall",  64'(start_cnt - s0), 64'd2);
    wait_result("t2a");
    release_result();
    repeat (5) @(negedge clk);
    chk("t2.starts_resume", 64'(start_cnt - s0), 64'd3);
    wait_result("t2b");
    release_result();
    wait_result("t2c");
    release_result();
    wait_result("t2d");
    release_result();

    // 3) short write count, then a clean job
    push_job(4'd8, 1);
    push_job(4'd9, 0);
    wait_result("t3a");
    release_result();
    wait_result("t3b");
    release_result();

    // 4) hung run is aborted by the watchdog
    push_job(4'd10, 2);
    w = 0;
    while (vex_nrst && w < TO + LIM) begin
      @(negedge clk);
      w++;
    end
    chk("t4.abort_seen", 64'(vex_nrst), 64'd0);
    lowc = 0;
    while (!vex_nrst && lowc < 10) begin
      lowc++;
      @(negedge clk);
    end
    chk("t4.vex_nrst_low_cycles", 64'(lowc), 64'd2);
    wait_result("t4");
    release_result();

    // 5) release one bank in the cycle the other bank commits
    push_job(4'd11, 0);
    push_job(4'd12, 0);
    wait_result("t5a");
    w = 0;
    while (!vex_done && w < LIM) begin
      @(negedge clk);
      w++;
    end
    chk("t5.done_seen", 64'(vex_done), 64'd1);
    @(negedge clk);
    chk("t5.commit_busy", 64'(busy), 64'd1);
    release_result();
    wait_result("t5b");
    release_result();
    repeat (3) @(negedge clk);
    chk("t5.no_dup", 64'(res_valid), 64'd0);
    chk("t5.idle",   64'(busy),      64'd0);

    // 6) reset in the middle of a run
    s0 = start_cnt;
    push_job(4'd13, 0);
    push_job(4'd14, 0);
    repeat (10) @(negedge clk);
    nrst = 1'b0;
    #1;
    chk("t6.vex_start", 64'(vex_start), 64'd0);
    chk("t6.vex_nrst",  64'(vex_nrst),  64'd0);
    chk("t6.busy",      64'(busy),      64'd0);
    chk("t6.job_ready", 64'(job_ready), 64'd1);
    chk("t6.res_valid", 64'(res_valid), 64'd0);
    chk("t6.bank_sel",  64'(bank_sel),  64'd0);
    chk("t6.vex_k",     vex_k_over_s,   64'd0);
    chk("t6.res_tag",   64'(res_tag),   64'd0);
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    exp_q.delete();
    mode_q.delete();
    obs_k_q.delete();
    obs_bank_q.delete();
    repeat (6) @(negedge clk);
    chk("t6.queue_empty", 64'(busy), 64'd0);
    chk("t6.no_restart",  64'(start_cnt - s0), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
